// File: rtl/mem_arbiter_if.sv
// Bus bundle between two cores (instruction + data ports), the arbiter and a single RAM port.
// The arbiter takes the slave modport; the core/RAM side takes master.
interface mem_arbiter_if;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       dREN;
  logic [1:0]       dWEN;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]       iwait;
  logic [1:0]       dwait;
  logic [31:0]      rdata;
  logic             err;
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  logic             ram_ready;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output iwait, dwait, rdata, err, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  iwait, dwait, rdata, err, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-core round-robin arbiter onto one RAM port: IDLE picks a requester, BUSY runs the
// RAM access (with timeout), RESP releases the winner's wait bit for exactly one cycle.
module mem_arbiter #(
  parameter int TIMEOUT_CYC = 64
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int CW = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic          rr;
  logic [CW-1:0] cnt;
  logic          gcore;
  logic          gdata;
  logic          ramren_q;
  logic          ramwen_q;
  logic [31:0]   ramaddr_q;
  logic [31:0]   ramstore_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [1:0]    iwait_q;
  logic [1:0]    dwait_q;

  logic [1:0]  req;
  logic        sel_core;
  logic        sel_data;
  logic        sel_write;
  logic [31:0] sel_addr;
  logic [31:0] sel_store;

  // Core rr gets first pick; within a core a data access beats a fetch, and dREN+dWEN is a write.
  always_comb begin
    req       = bus.iREN | bus.dREN | bus.dWEN;
    sel_core  = req[rr] ? rr : ~rr;
    sel_data  = bus.dREN[sel_core] | bus.dWEN[sel_core];
    sel_write = bus.dWEN[sel_core];
    sel_addr  = sel_data ? bus.daddr[sel_core] : bus.iaddr[sel_core];
    sel_store = sel_write ? bus.dstore[sel_core] : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr         <= 1'b0;
      cnt        <= '0;
      gcore      <= 1'b0;
      gdata      <= 1'b0;
      ramren_q   <= 1'b0;
      ramwen_q   <= 1'b0;
      ramaddr_q  <= 32'h0;
      ramstore_q <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      iwait_q    <= 2'b11;
      dwait_q    <= 2'b11;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gcore      <= sel_core;
            gdata      <= sel_data;
            ramren_q   <= ~sel_write;
            ramwen_q   <= sel_write;
            ramaddr_q  <= sel_addr;
            ramstore_q <= sel_store;
            cnt        <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // A ready pulse on the final counted cycle still counts as a normal completion.
          if (bus.ram_ready || (cnt == CW'(TIMEOUT_CYC - 1))) begin
            ramren_q   <= 1'b0;
            ramwen_q   <= 1'b0;
            ramaddr_q  <= 32'h0;
            ramstore_q <= 32'h0;
            rdata_q    <= bus.ram_ready ? bus.ramload : 32'h0;
            err_q      <= ~bus.ram_ready;
            if (gdata) dwait_q[gcore] <= 1'b0;
            else       iwait_q[gcore] <= 1'b0;
            state      <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          iwait_q <= 2'b11;
          dwait_q <= 2'b11;
          err_q   <= 1'b0;
          rr      <= ~gcore;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ramREN   = ramren_q;
  assign bus.ramWEN   = ramwen_q;
  assign bus.ramaddr  = ramaddr_q;
  assign bus.ramstore = ramstore_q;
  assign bus.rdata    = rdata_q;
  assign bus.err      = err_q;
  assign bus.iwait    = iwait_q;
  assign bus.dwait    = dwait_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (TIMEOUT_CYC=4): a table of single transactions
// checked through a response scoreboard, then hand-written alternation/reset/drop sequences.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter #(.TIMEOUT_CYC(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [1:0]  iren, dren, dwen;
    logic [31:0] ia0, ia1, da0, da1, ds0, ds1;
    int          delay;
    logic        drop;
    logic [31:0] load;
    logic        eren, ewen;
    logic [31:0] eaddr, estore;
    logic [3:0]  ewait;
    logic [31:0] erdata;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic [3:0]  ewait;
    logic [31:0] erdata;
    logic        eerr;
  } resp_t;

  resp_t sbq[$];
  vec_t  vecs[7];
  int    total = 0;
  int    bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    bus.iREN = 2'b00; bus.dREN = 2'b00; bus.dWEN = 2'b00;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    bus.ram_ready = 1'b0; bus.ramload = 32'h0;
  endtask

  function automatic logic in_resp();
    return ({bus.iwait, bus.dwait} != 4'b1111);
  endfunction

  task automatic checkResp(input string tag);
    resp_t e;
    if (sbq.size() == 0) begin
      checkOutput({tag, "_unexpected_resp"}, 32'h1, 32'h0);
    end else begin
      e = sbq.pop_front();
      checkOutput({tag, "_waits"}, {28'h0, bus.iwait, bus.dwait}, {28'h0, e.ewait});
      checkOutput({tag, "_rdata"}, bus.rdata, e.erdata);
      checkOutput({tag, "_err"}, {31'h0, bus.err}, {31'h0, e.eerr});
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearInputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One full transaction from IDLE: drive, check BUSY outputs, answer RAM, check RESP, release.
  task automatic applyStimulus(input vec_t v);
    int  k;
    bit  done;
    int  explen;
    bus.iREN = v.iren; bus.dREN = v.dren; bus.dWEN = v.dwen;
    bus.iaddr[0] = v.ia0; bus.iaddr[1] = v.ia1;
    bus.daddr[0] = v.da0; bus.daddr[1] = v.da1;
    bus.dstore[0] = v.ds0; bus.dstore[1] = v.ds1;
    bus.ram_ready = 1'b0;
    sbq.push_back('{v.ewait, v.erdata, v.eerr});
    explen = (v.delay < 4) ? v.delay + 1 : 4;
    @(negedge clk);
    checkOutput("busy_ren", {31'h0, bus.ramREN}, {31'h0, v.eren});
    checkOutput("busy_wen", {31'h0, bus.ramWEN}, {31'h0, v.ewen});
    checkOutput("busy_addr", bus.ramaddr, v.eaddr);
    checkOutput("busy_store", bus.ramstore, v.estore);
    bus.iaddr = {2{32'hFFFF_0001}};
    bus.daddr = {2{32'hFFFF_0002}};
    bus.dstore = {2{32'hFFFF_0003}};
    if (v.drop) begin
      bus.iREN = 2'b00; bus.dREN = 2'b00; bus.dWEN = 2'b00;
    end
    k = 0;
    done = 0;
    while (!done && k < 10) begin
      if (k == v.delay) begin
        bus.ram_ready = 1'b1;
        bus.ramload = v.load;
      end
      @(negedge clk);
      bus.ram_ready = 1'b0;
      bus.ramload = 32'h0BAD_0BAD;
      if (in_resp()) begin
        done = 1;
      end else begin
        checkOutput("hold_addr", bus.ramaddr, v.eaddr);
        k++;
      end
    end
    if (!done) begin
      checkOutput("resp_never_seen", 32'h0, 32'h1);
      void'(sbq.pop_front());
    end else begin
      checkOutput("busy_len", k + 1, explen);
      checkResp("vec");
      checkOutput("resp_ren_low", {31'h0, bus.ramREN | bus.ramWEN}, 32'h0);
    end
    clearInputs();
    @(negedge clk);
    checkOutput("after_resp_waits", {28'h0, bus.iwait, bus.dwait}, 32'hF);
    checkOutput("after_resp_ren", {31'h0, bus.ramREN}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int got;
    // Expectations assume rr=0 after reset and that it flips to the other core after each grant.
    vecs[0] = '{2'b01, 2'b00, 2'b00, 32'h100, 0, 0, 0, 0, 0, 0, 1'b0, 32'hDEAD_BEEF,
                1'b1, 1'b0, 32'h100, 32'h0, 4'b1011, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{2'b00, 2'b11, 2'b00, 0, 0, 32'h200, 32'h300, 0, 0, 1, 1'b0, 32'h1111_1111,
                1'b1, 1'b0, 32'h300, 32'h0, 4'b1101, 32'h1111_1111, 1'b0};
    vecs[2] = '{2'b01, 2'b00, 2'b01, 32'h104, 0, 32'h200, 0, 32'h5A, 0, 2, 1'b0, 32'hAAAA_5555,
                1'b0, 1'b1, 32'h200, 32'h5A, 4'b1110, 32'hAAAA_5555, 1'b0};
    vecs[3] = '{2'b01, 2'b00, 2'b00, 32'h104, 0, 0, 0, 0, 0, 3, 1'b0, 32'h1234_5678,
                1'b1, 1'b0, 32'h104, 32'h0, 4'b1011, 32'h1234_5678, 1'b0};
    vecs[4] = '{2'b00, 2'b10, 2'b00, 0, 0, 0, 32'h400, 0, 0, 99, 1'b0, 32'h1234_0000,
                1'b1, 1'b0, 32'h400, 32'h0, 4'b1101, 32'h0, 1'b1};
    vecs[5] = '{2'b00, 2'b01, 2'b01, 0, 0, 32'h500, 0, 32'hCAFE, 0, 0, 1'b0, 32'h77,
                1'b0, 1'b1, 32'h500, 32'hCAFE, 4'b1110, 32'h77, 1'b0};
    vecs[6] = '{2'b10, 2'b01, 2'b00, 0, 32'h600, 32'h700, 0, 0, 0, 0, 1'b1, 32'h99,
                1'b1, 1'b0, 32'h600, 32'h0, 4'b0111, 32'h99, 1'b0};

    doReset();
    checkOutput("rst_waits", {28'h0, bus.iwait, bus.dwait}, 32'hF);
    checkOutput("rst_ram_en", {30'h0, bus.ramREN, bus.ramWEN}, 32'h0);
    checkOutput("rst_ramaddr", bus.ramaddr, 32'h0);
    checkOutput("rst_ramstore", bus.ramstore, 32'h0);
    checkOutput("rst_rdata", bus.rdata, 32'h0);
    checkOutput("rst_err", {31'h0, bus.err}, 32'h0);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Both cores hold dREN: grants must alternate 0,1,0,1.
    doReset();
    bus.dREN = 2'b11;
    bus.daddr[0] = 32'h10;
    bus.daddr[1] = 32'h20;
    for (int n = 0; n < 2; n++) begin
      sbq.push_back('{4'b1110, 32'hC0DE_0010, 1'b0});
      sbq.push_back('{4'b1101, 32'hC0DE_0020, 1'b0});
    end
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      @(negedge clk);
      if (bus.ramREN) begin
        bus.ram_ready = 1'b1;
        bus.ramload = 32'hC0DE_0000 | bus.ramaddr;
      end else begin
        bus.ram_ready = 1'b0;
      end
      if (in_resp()) begin
        checkResp("rr");
        got++;
      end
    end
    checkOutput("rr_grant_count", got, 4);
    sbq.delete();
    clearInputs();
    @(negedge clk);

    // Reset in the middle of a write abandons it; a later stray ready is ignored.
    doReset();
    bus.dWEN = 2'b01;
    bus.daddr[0] = 32'h800;
    bus.dstore[0] = 32'h33;
    @(negedge clk);
    checkOutput("midrst_busy_wen", {31'h0, bus.ramWEN}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ram_en", {30'h0, bus.ramREN, bus.ramWEN}, 32'h0);
    checkOutput("midrst_waits", {28'h0, bus.iwait, bus.dwait}, 32'hF);
    checkOutput("midrst_ramaddr", bus.ramaddr, 32'h0);
    checkOutput("midrst_ramstore", bus.ramstore, 32'h0);
    rst = 1'b0;
    clearInputs();
    bus.ram_ready = 1'b1;
    bus.ramload = 32'h5555_AAAA;
    @(negedge clk);
    bus.ram_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      checkOutput("stray_ready_waits", {28'h0, bus.iwait, bus.dwait}, 32'hF);
      checkOutput("stray_ready_ram_en", {30'h0, bus.ramREN, bus.ramWEN}, 32'h0);
      checkOutput("stray_ready_rdata", bus.rdata, 32'h0);
      @(negedge clk);
    end

    // Core1 drops its read mid-access while core0 starts asking; core0 follows after one RESP.
    doReset();
    bus.dREN = 2'b10;
    bus.daddr[1] = 32'h900;
    @(negedge clk);
    checkOutput("drop_busy_addr", bus.ramaddr, 32'h900);
    bus.dREN = 2'b01;
    bus.daddr[0] = 32'hA00;
    bus.daddr[1] = 32'hBBBB;
    bus.ram_ready = 1'b1;
    bus.ramload = 32'h4242;
    @(negedge clk);
    bus.ram_ready = 1'b0;
    checkOutput("drop_resp_waits", {28'h0, bus.iwait, bus.dwait}, 32'hD);
    checkOutput("drop_resp_rdata", bus.rdata, 32'h4242);
    @(negedge clk);
    checkOutput("drop_idle_waits", {28'h0, bus.iwait, bus.dwait}, 32'hF);
    @(negedge clk);
    checkOutput("drop_next_ren", {31'h0, bus.ramREN}, 32'h1);
    checkOutput("drop_next_addr", bus.ramaddr, 32'hA00);
    bus.ram_ready = 1'b1;
    bus.ramload = 32'h6161;
    @(negedge clk);
    bus.ram_ready = 1'b0;
    checkOutput("drop_next_waits", {28'h0, bus.iwait, bus.dwait}, 32'hE);
    checkOutput("drop_next_rdata", bus.rdata, 32'h6161);
    clearInputs();
    @(negedge clk);
    checkOutput("drop_final_waits", {28'h0, bus.iwait, bus.dwait}, 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
